// File: rtl/fft_sequencer.sv
// rtl/fft_sequencer.sv - FFT sample RAM phase sequencer (load, start, calc, unload)
// Owns the single-port RAM mux and flags bad length, access collisions and core timeout.
module fft_sequencer #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_WIDTH-1:0] i_samples_number,
    input  logic                  i_br_write,
    input  logic                  i_br_read,
    input  logic [ADDR_WIDTH-1:0] i_br_index,
    input  logic [15:0]           i_br_sample,
    input  logic                  i_br_data_loaded,
    output logic                  o_br_calc_end,
    output logic [DATA_WIDTH-1:0] o_br_rdata,
    output logic                  o_fft_start,
    output logic [ADDR_WIDTH-1:0] o_fft_n,
    input  logic                  i_fft_req,
    input  logic                  i_fft_we,
    input  logic [ADDR_WIDTH-1:0] i_fft_addr,
    input  logic [DATA_WIDTH-1:0] i_fft_wdata,
    input  logic                  i_fft_done,
    output logic [DATA_WIDTH-1:0] o_fft_rdata,
    output logic                  o_ram_en,
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_wdata,
    input  logic [DATA_WIDTH-1:0] i_ram_rdata,
    input  logic                  i_err_clr,
    output logic [2:0]            o_err_flags,
    output logic [1:0]            o_phase
);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        START  = 2'd1,
        CALC   = 2'd2,
        UNLOAD = 2'd3
    } phase_t;

    localparam logic [ADDR_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [31:0]           TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    phase_t                state, state_next;
    logic [ADDR_WIDTH-1:0] load_cnt, load_cnt_next;
    logic [ADDR_WIDTH-1:0] unload_cnt, unload_cnt_next;
    logic [ADDR_WIDTH-1:0] fft_n, fft_n_next;
    logic [31:0]           to_cnt, to_cnt_next;
    logic [2:0]            err_flags, err_set;
    logic                  br_rd, br_rd_q;

    logic [ADDR_WIDTH-1:0] load_cnt_inc, load_cnt_eff, unload_cnt_inc;
    logic                  n_valid;

    assign load_cnt_inc   = (load_cnt == CNT_MAX) ? load_cnt : load_cnt + 1'b1;
    assign load_cnt_eff   = i_br_write ? load_cnt_inc : load_cnt;
    assign unload_cnt_inc = unload_cnt + 1'b1;
    // A write in the same cycle as data_loaded counts toward the loaded length.
    assign n_valid = (i_samples_number >= ADDR_WIDTH'(2))
                  && ((i_samples_number & (i_samples_number - 1'b1)) == '0)
                  && (load_cnt_eff >= i_samples_number);

    always_comb begin
        state_next      = state;
        load_cnt_next   = load_cnt;
        unload_cnt_next = unload_cnt;
        fft_n_next      = fft_n;
        to_cnt_next     = to_cnt;
        err_set         = '0;
        br_rd           = 1'b0;
        o_ram_en        = 1'b0;
        o_ram_we        = 1'b0;
        o_ram_addr      = '0;
        o_ram_wdata     = '0;
        o_fft_start     = 1'b0;
        o_br_calc_end   = 1'b0;
        case (state)
            LOAD: begin
                if (i_br_write) begin
                    o_ram_en                        = 1'b1;
                    o_ram_we                        = 1'b1;
                    o_ram_addr                      = i_br_index;
                    o_ram_wdata[DATA_WIDTH-1 -: 16] = i_br_sample;
                    load_cnt_next                   = load_cnt_inc;
                end
                if (i_br_read) err_set[1] = 1'b1;
                if (i_br_data_loaded) begin
                    fft_n_next = i_samples_number;
                    if (n_valid) begin
                        state_next = START;
                    end else begin
                        err_set[0]    = 1'b1;
                        load_cnt_next = '0;
                    end
                end
            end
            START: begin
                o_fft_start = 1'b1;
                to_cnt_next = '0;
                state_next  = CALC;
            end
            CALC: begin
                o_ram_en    = i_fft_req;
                o_ram_we    = i_fft_req & i_fft_we;
                o_ram_addr  = i_fft_addr;
                o_ram_wdata = i_fft_wdata;
                to_cnt_next = to_cnt + 32'd1;
                if (i_br_write || i_br_read) err_set[1] = 1'b1;
                if (i_fft_done) begin
                    state_next      = UNLOAD;
                    unload_cnt_next = '0;
                end else if (to_cnt == TO_LAST) begin
                    err_set[2]      = 1'b1;
                    state_next      = LOAD;
                    load_cnt_next   = '0;
                    unload_cnt_next = '0;
                end
            end
            UNLOAD: begin
                o_br_calc_end = 1'b1;
                if (i_br_write) err_set[1] = 1'b1;
                if (i_br_read) begin
                    o_ram_en        = 1'b1;
                    o_ram_addr      = i_br_index;
                    br_rd           = 1'b1;
                    unload_cnt_next = unload_cnt_inc;
                    if (unload_cnt_inc == fft_n) begin
                        state_next      = LOAD;
                        load_cnt_next   = '0;
                        unload_cnt_next = '0;
                    end
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= LOAD;
            load_cnt   <= '0;
            unload_cnt <= '0;
            fft_n      <= '0;
            to_cnt     <= '0;
            err_flags  <= '0;
            br_rd_q    <= 1'b0;
        end else begin
            state      <= state_next;
            load_cnt   <= load_cnt_next;
            unload_cnt <= unload_cnt_next;
            fft_n      <= fft_n_next;
            to_cnt     <= to_cnt_next;
            // A new event in the clearing cycle survives the clear.
            err_flags  <= (i_err_clr ? 3'b000 : err_flags) | err_set;
            br_rd_q    <= br_rd;
        end
    end

    assign o_phase     = state;
    assign o_fft_n     = fft_n;
    assign o_err_flags = err_flags;
    assign o_fft_rdata = i_ram_rdata;
    assign o_br_rdata  = br_rd_q ? i_ram_rdata : '0;

endmodule
